iot_sequencer: RTL
==================

// Module: iot_sequencer
// PURPOSE
//  Sequences PDP-8 IOT instructions (6xxx) from the CPU onto the shared IO bus.
//  Issues one single-cycle io_req per IOT and merges ack/skip/sac/rdata from NDEV devices (teletype etc.).
//  Returns a registered result to the CPU, runs CAF (6007) and aggregates device IRQs into int_req.
//  Sits between the CPU execute FSM and all IO devices; devices respond combinationally to io_req.
// PARAMETERS
//  NDEV      4           number of device response slots (1..16)
//  IRQ_MASK  {NDEV{1'b1}} per-slot IRQ enable mask (static)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        reset, asynchronous assert, active-low
//  iot_start    in   1        CPU pulse: execute IOT in iot_instr (ignored unless IDLE)
//  iot_instr    in   12       IOT word; [8:3]=device, [2:0]=op; [11:9] must be 3'o6
//  iot_ac       in   12       CPU AC at start
//  iot_busy     out  1        high in REQ and DONE
//  iot_done     out  1        one-cycle completion strobe
//  iot_skip     out  1        valid with iot_done: skip next instruction
//  iot_ac_load  out  1        valid with iot_done: load AC from iot_ac_out
//  iot_ac_out   out  12       OR of rdata of all slots asserting sac
//  iot_nodev    out  1        valid with iot_done: no slot acked
//  io_dev       out  6        bus device select
//  io_op        out  3        bus op
//  io_req       out  1        bus request, exactly one cycle per IOT
//  io_wdata     out  12       bus write data (latched iot_ac)
//  io_caf       out  1        clear-all-flags pulse
//  dev_ack      in   NDEV     per-slot acknowledge
//  dev_skip     in   NDEV     per-slot skip
//  dev_sac      in   NDEV     per-slot set-AC
//  dev_rdata    in   12*NDEV  per-slot read data, slot i at [12i+11:12i]
//  dev_irq      in   NDEV     per-slot interrupt request (level)
//  int_req      out  1        registered interrupt request to CPU
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; io_dev/io_op/io_wdata 0; sticky flags cleared.
//  FSM IDLE -> REQ -> DONE -> IDLE; iot_start sampled only in IDLE.
//  IDLE: on iot_start latch dev/op/ac; device 0 op 7 (CAF) -> REQ with io_caf=1 instead of io_req.
//   Device 0 ops 0..6 (ION/IOF etc., CPU-internal): go to DONE directly, no bus cycle, nodev=0.
//  REQ (1 cycle): io_req=1 (or io_caf=1), io_dev/io_op/io_wdata stable; register responses:
//   skip=|dev_skip, ac_load=|dev_sac, ac_out=OR(rdata[i] & {12{sac[i]}}), nodev=~|dev_ack.
//   CAF cycle: skip=0, ac_load=1, ac_out=0 (CAF clears AC), nodev=0.
//  DONE (1 cycle): iot_done=1 with registered results; busy=1; bus outputs hold, io_req=0.
//  Latency: iot_start at cycle N -> io_req at N+1 -> iot_done at N+2; back-to-back start at N+3.
//  io_req never held >1 cycle (devices act on every req cycle: tx_write, flag clears).
//  Multiple sac: rdata OR-merged (wired-OR bus); multiple skip: OR.
//  iot_instr[11:9]!=3'o6 at start: treated as nodev, no bus cycle, DONE next cycle.
//  int_req <= |(dev_irq & IRQ_MASK) each cycle; forced 0 in the cycle after io_caf.
//  Reset mid-operation: immediate return to IDLE; io_req/io_caf drop asynchronously; no done.
// CONFIGURATION
//  IOT_NOACK_IRQ_EN defined: REQ with nodev sets sticky nodev_err; int_req also asserted while
//   nodev_err=1; cleared by CAF or reset. Undefined: nodev reported only via iot_nodev; no sticky state.
// STRUCTURE
//  Shared header pdp8.h: IOT opcode 3'o6, device numbers (DEV_TTY_RX/TX, DEV_CPU=0),
//   op codes (OP_CAF=3'o7), FSM state encoding (IDLE/REQ/DONE).
//  Sub-module iot_resp_merge: combinational NDEV-way OR-reduce of skip/sac/ack/gated rdata.
// TESTING
//  1. TLS 6046, AC=0101, slot ack=1 -> io_req 1 cycle, io_dev=04, io_op=6, io_wdata=0101; done at N+2, skip=0, ac_load=0.
//  2. KRB 6036, slot sac=1 rdata=0301 -> iot_ac_load=1, iot_ac_out=0301, nodev=0.
//  3. KSF 6031 with skip=1 on slot0 and sac=1 rdata=0017 / 0360 on slots 1,2 -> skip=1, ac_out=0377.
//  4. 6007 -> io_caf 1 cycle, io_req=0, ac_load=1, ac_out=0000; int_req=0 next cycle despite dev_irq=1.
//  5. 6553 no ack -> iot_nodev=1; with IOT_NOACK_IRQ_EN int_req=1 until 6007; without, int_req stays 0.
//  6. rst_n low during REQ -> io_req 0 immediately, no iot_done; iot_start held in REQ/DONE ignored.

Source files
------------

// File: rtl/iot_sequencer_pkg.sv
// Shared PDP-8 IOT definitions: opcode, device and op numbers, FSM encoding.
package iot_sequencer_pkg;

  localparam logic [2:0] IOT_OPCODE = 3'o6;

  localparam logic [5:0] DEV_CPU    = 6'o00;
  localparam logic [5:0] DEV_TTY_RX = 6'o03;
  localparam logic [5:0] DEV_TTY_TX = 6'o04;

  localparam logic [2:0] OP_CAF = 3'o7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } iot_state_e;

  // CAF is device 0 op 7; it is the only CPU-internal IOT that drives the bus.
  function automatic logic is_caf(input logic [5:0] dev, input logic [2:0] op);
    return (dev == DEV_CPU) && (op == OP_CAF);
  endfunction

endpackage

// File: rtl/iot_sequencer_if.sv
// Shared IO bus between the IOT sequencer (master) and the device slots (slave).
interface iot_sequencer_if #(
  parameter int NDEV = 4
) ();
  logic [5:0]         io_dev;
  logic [2:0]         io_op;
  logic               io_req;
  logic [11:0]        io_wdata;
  logic               io_caf;
  logic [NDEV-1:0]    dev_ack;
  logic [NDEV-1:0]    dev_skip;
  logic [NDEV-1:0]    dev_sac;
  logic [12*NDEV-1:0] dev_rdata;
  logic [NDEV-1:0]    dev_irq;

  modport master (
    output io_dev, io_op, io_req, io_wdata, io_caf,
    input  dev_ack, dev_skip, dev_sac, dev_rdata, dev_irq
  );

  modport slave (
    input  io_dev, io_op, io_req, io_wdata, io_caf,
    output dev_ack, dev_skip, dev_sac, dev_rdata, dev_irq
  );
endinterface

// File: rtl/iot_sequencer_resp_merge.sv
// Combinational wired-OR merge of all device slot responses.
module iot_resp_merge #(
  parameter int NDEV = 4
) (
  input  logic [NDEV-1:0]    ack_i,
  input  logic [NDEV-1:0]    skip_i,
  input  logic [NDEV-1:0]    sac_i,
  input  logic [12*NDEV-1:0] rdata_i,
  output logic               any_ack_o,
  output logic               any_skip_o,
  output logic               any_sac_o,
  output logic [11:0]        rdata_o
);
  logic [11:0] gated [NDEV];

  // A slot only contributes read data while it asserts sac.
  generate
    for (genvar gi = 0; gi < NDEV; gi++) begin : g_gate
      assign gated[gi] = rdata_i[12*gi +: 12] & {12{sac_i[gi]}};
    end
  endgenerate

  // OR-reduce the gated read data across slots.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NDEV; i++) rdata_o = rdata_o | gated[i];
  end

  assign any_ack_o  = |ack_i;
  assign any_skip_o = |skip_i;
  assign any_sac_o  = |sac_i;
endmodule

// File: rtl/iot_sequencer.sv
// PDP-8 IOT sequencer: issues one bus cycle per IOT, merges device responses,
// runs CAF and aggregates device interrupts.
// Optional: define IOT_NOACK_IRQ_EN to latch unacknowledged IOTs into a sticky
// error that also raises int_req until CAF or reset.
module iot_sequencer
  import iot_sequencer_pkg::*;
#(
  parameter int              NDEV     = 4,
  parameter logic [NDEV-1:0] IRQ_MASK = {NDEV{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iot_start_i,
  input  logic [11:0]            iot_instr_i,
  input  logic [11:0]            iot_ac_i,
  output logic                   iot_busy_o,
  output logic                   iot_done_o,
  output logic                   iot_skip_o,
  output logic                   iot_ac_load_o,
  output logic [11:0]            iot_ac_out_o,
  output logic                   iot_nodev_o,
  output logic                   int_req_o,
  iot_sequencer_if.master        bus
);
  iot_state_e  state_q;
  logic [5:0]  io_dev_q;
  logic [2:0]  io_op_q;
  logic [11:0] io_wdata_q;
  logic        io_req_q, io_caf_q;
  logic        busy_q, done_q, skip_q, ac_load_q, nodev_q, int_req_q;
  logic [11:0] ac_out_q;

  logic        any_ack, any_skip, any_sac;
  logic [11:0] merged_rdata;
  logic        irq_src;

  iot_resp_merge #(.NDEV(NDEV)) u_merge (
    .ack_i      (bus.dev_ack),
    .skip_i     (bus.dev_skip),
    .sac_i      (bus.dev_sac),
    .rdata_i    (bus.dev_rdata),
    .any_ack_o  (any_ack),
    .any_skip_o (any_skip),
    .any_sac_o  (any_sac),
    .rdata_o    (merged_rdata)
  );

`ifdef IOT_NOACK_IRQ_EN
  logic nodev_err_q;

  // Sticky error: set by an unacknowledged bus IOT, cleared by CAF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nodev_err_q <= 1'b0;
    end else if (state_q == ST_REQ) begin
      if (io_caf_q)      nodev_err_q <= 1'b0;
      else if (!any_ack) nodev_err_q <= 1'b1;
    end
  end

  assign irq_src = (|(bus.dev_irq & IRQ_MASK)) | nodev_err_q;
`else
  assign irq_src = |(bus.dev_irq & IRQ_MASK);
`endif

  // Main IOT FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      io_dev_q   <= '0;
      io_op_q    <= '0;
      io_wdata_q <= '0;
      io_req_q   <= 1'b0;
      io_caf_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      skip_q     <= 1'b0;
      ac_load_q  <= 1'b0;
      ac_out_q   <= '0;
      nodev_q    <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      // Interrupts are suppressed for the cycle that follows a CAF pulse.
      int_req_q <= io_caf_q ? 1'b0 : irq_src;
      case (state_q)
        ST_IDLE: begin
          if (iot_start_i) begin
            io_dev_q   <= iot_instr_i[8:3];
            io_op_q    <= iot_instr_i[2:0];
            io_wdata_q <= iot_ac_i;
            busy_q     <= 1'b1;
            skip_q     <= 1'b0;
            ac_load_q  <= 1'b0;
            ac_out_q   <= '0;
            nodev_q    <= 1'b0;
            if (iot_instr_i[11:9] != IOT_OPCODE) begin
              // Not an IOT word: finish at once as if nothing answered.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              nodev_q <= 1'b1;
            end else if (is_caf(iot_instr_i[8:3], iot_instr_i[2:0])) begin
              state_q  <= ST_REQ;
              io_caf_q <= 1'b1;
            end else if (iot_instr_i[8:3] == DEV_CPU) begin
              // CPU-internal ops (ION/IOF...) never touch the bus.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_REQ;
              io_req_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          io_req_q <= 1'b0;
          io_caf_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
          if (io_caf_q) begin
            skip_q    <= 1'b0;
            ac_load_q <= 1'b1;
            ac_out_q  <= '0;
            nodev_q   <= 1'b0;
          end else begin
            skip_q    <= any_skip;
            ac_load_q <= any_sac;
            ac_out_q  <= merged_rdata;
            nodev_q   <= ~any_ack;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          skip_q    <= 1'b0;
          ac_load_q <= 1'b0;
          ac_out_q  <= '0;
          nodev_q   <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.io_dev    = io_dev_q;
  assign bus.io_op     = io_op_q;
  assign bus.io_req    = io_req_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.io_caf    = io_caf_q;
  assign iot_busy_o    = busy_q;
  assign iot_done_o    = done_q;
  assign iot_skip_o    = skip_q;
  assign iot_ac_load_o = ac_load_q;
  assign iot_ac_out_o  = ac_out_q;
  assign iot_nodev_o   = nodev_q;
  assign int_req_o     = int_req_q;
endmodule
